// File: rtl/tc_pcie_rx_gearbox.sv
// PHY rx gearbox: packs 1..MAX_SYMS-symbol beats into full OUT_W-bit words
// presented on a valid/ready output, with realign, flush and error pulses.
module tc_pcie_rx_gearbox #(
    parameter int SYM_W = 10,
    parameter int MAX_SYMS = 8,
    localparam int OUT_W = SYM_W * MAX_SYMS,
    localparam int WSEL_W = $clog2($clog2(MAX_SYMS) + 1)
) (
    input  logic              rxclk_i,
    input  logic              reset_i,
    input  logic [WSEL_W-1:0] rxwidth_i,
    input  logic              rxvalid_i,
    input  logic [OUT_W-1:0]  rxdata_i,
    input  logic              flush_i,
    output logic [OUT_W-1:0]  rxdata_o,
    output logic              rxvalid_o,
    input  logic              rxready_i,
    output logic              realign_o,
    output logic              overflow_o,
    output logic              width_err_o
);
    localparam int LOG_MAX = $clog2(MAX_SYMS);
    localparam int FILL_W = LOG_MAX;

    logic [FILL_W-1:0] fill_q, fill_d;
    logic [WSEL_W-1:0] width_q, width_d;
    logic [OUT_W-1:0]  acc_q, acc_d;
    logic [OUT_W-1:0]  out_q, out_d;
    logic              vld_q, vld_d;
    logic              realign_q, realign_d;
    logic              overflow_q, overflow_d;
    logic              werr_q, werr_d;

    logic [OUT_W-1:0]  acc_new;
    logic              legal;
    logic              word_done;
    int                base_s;
    int                nsym_s;

    always_comb begin
        acc_d      = acc_q;
        fill_d     = fill_q;
        width_d    = width_q;
        out_d      = out_q;
        vld_d      = vld_q;
        realign_d  = 1'b0;
        overflow_d = 1'b0;
        werr_d     = 1'b0;
        acc_new    = acc_q;
        word_done  = 1'b0;
        base_s     = 0;
        nsym_s     = 0;
        legal      = int'(rxwidth_i) <= LOG_MAX;

        if (vld_q && rxready_i)
            vld_d = 1'b0;

        if (flush_i) begin
            fill_d = '0;
        end else if (rxvalid_i && !legal) begin
            werr_d = 1'b1;
        end else if (rxvalid_i) begin
            nsym_s = 1 << rxwidth_i;
            base_s = int'(fill_q);
            if (fill_q != '0 && rxwidth_i != width_q) begin
                realign_d = 1'b1;
                base_s    = 0;
            end
            // A fresh alignment starts from a clean accumulator so stale symbols never leak
            if (base_s == 0)
                acc_new = '0;
            width_d = rxwidth_i;
            for (int i = 0; i < MAX_SYMS; i++) begin
                if (i < nsym_s && base_s + i < MAX_SYMS)
                    acc_new[(base_s + i) * SYM_W +: SYM_W] = rxdata_i[i * SYM_W +: SYM_W];
            end
            acc_d = acc_new;
            if (base_s + nsym_s >= MAX_SYMS) begin
                fill_d    = '0;
                word_done = 1'b1;
            end else begin
                fill_d = FILL_W'(base_s + nsym_s);
            end
        end

        // A held, unaccepted word wins over a newly completed one
        if (word_done) begin
            if (vld_q && !rxready_i) begin
                overflow_d = 1'b1;
            end else begin
                out_d = acc_new;
                vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge rxclk_i) begin
        if (reset_i) begin
            fill_q     <= '0;
            width_q    <= '0;
            acc_q      <= '0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            realign_q  <= 1'b0;
            overflow_q <= 1'b0;
            werr_q     <= 1'b0;
        end else begin
            fill_q     <= fill_d;
            width_q    <= width_d;
            acc_q      <= acc_d;
            out_q      <= out_d;
            vld_q      <= vld_d;
            realign_q  <= realign_d;
            overflow_q <= overflow_d;
            werr_q     <= werr_d;
        end
    end

    assign rxdata_o    = out_q;
    assign rxvalid_o   = vld_q;
    assign realign_o   = realign_q;
    assign overflow_o  = overflow_q;
    assign width_err_o = werr_q;

endmodule

// File: tb/tb_tc_pcie_rx_gearbox.sv
// Directed bench for tc_pcie_rx_gearbox: an 8-symbol instance for packing and
// handshake scenarios, a 4-symbol instance for illegal-width handling.
module tb_tc_pcie_rx_gearbox;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_i;
    logic [1:0]  rxwidth;
    logic        rxvalid;
    logic [79:0] rxdata;
    logic        flush;
    logic        ready;
    logic [79:0] dout;
    logic        vld, realign, ovf, werr;

    logic [1:0]  w4;
    logic        v4;
    logic [39:0] d4;
    logic        f4, r4;
    logic [39:0] dout4;
    logic        vld4, realign4, ovf4, werr4;

    int n_cmp = 0;
    int n_err = 0;

    tc_pcie_rx_gearbox #(.SYM_W(10), .MAX_SYMS(8)) u_dut (
        .rxclk_i(clk), .reset_i(reset_i), .rxwidth_i(rxwidth), .rxvalid_i(rxvalid),
        .rxdata_i(rxdata), .flush_i(flush), .rxdata_o(dout), .rxvalid_o(vld),
        .rxready_i(ready), .realign_o(realign), .overflow_o(ovf), .width_err_o(werr)
    );

    tc_pcie_rx_gearbox #(.SYM_W(10), .MAX_SYMS(4)) u_dut4 (
        .rxclk_i(clk), .reset_i(reset_i), .rxwidth_i(w4), .rxvalid_i(v4),
        .rxdata_i(d4), .flush_i(f4), .rxdata_o(dout4), .rxvalid_o(vld4),
        .rxready_i(r4), .realign_o(realign4), .overflow_o(ovf4), .width_err_o(werr4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [1:0] w, input logic [79:0] d);
        rxwidth = w;
        rxvalid = 1'b1;
        rxdata  = d;
        tick();
        rxvalid = 1'b0;
    endtask

    task automatic beat4(input logic [1:0] w, input logic [39:0] d);
        w4 = w;
        v4 = 1'b1;
        d4 = d;
        tick();
        v4 = 1'b0;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        tick();
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %b want 0", vld); end
        n_cmp++; if (dout !== 80'h0) begin n_err++; $display("FAIL reset_data got %h want 0", dout); end
        n_cmp++; if ({realign, ovf, werr} !== 3'b000) begin n_err++; $display("FAIL reset_pulses got %b want 000", {realign, ovf, werr}); end
        n_cmp++; if ({vld4, realign4, ovf4, werr4} !== 4'b0000) begin n_err++; $display("FAIL reset_dut4 got %b want 0000", {vld4, realign4, ovf4, werr4}); end
        reset_i = 1'b0;
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_idle_vld got %b want 0", vld); end
    endtask

    task automatic test_narrow();
        logic [79:0] exp;
        exp   = '0;
        ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp[i*10 +: 10] = 10'(i + 1);
            beat(2'd0, 80'(i + 1));
            if (i == 6) begin
                n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL narrow_early_vld got %b want 0", vld); end
            end
        end
        n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL narrow_vld got %b want 1", vld); end
        n_cmp++; if (dout[9:0] !== 10'h001) begin n_err++; $display("FAIL narrow_first_sym got %h want 001", dout[9:0]); end
        n_cmp++; if (dout[79:70] !== 10'h008) begin n_err++; $display("FAIL narrow_last_sym got %h want 008", dout[79:70]); end
        n_cmp++; if (dout !== exp) begin n_err++; $display("FAIL narrow_word got %h want %h", dout, exp); end
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL narrow_drop_vld got %b want 0", vld); end
    endtask

    task automatic test_back_to_back();
        logic [79:0] w;
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            for (int s = 0; s < 8; s++)
                w[s*10 +: 10] = 10'(k * 16 + s + 1);
            beat(2'd3, w);
            n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL b2b_vld[%0d] got %b want 1", k, vld); end
            n_cmp++; if (dout !== w) begin n_err++; $display("FAIL b2b_word[%0d] got %h want %h", k, dout, w); end
            if (k == 0) begin
                n_cmp++; if (realign !== 1'b0) begin n_err++; $display("FAIL b2b_realign got %b want 0", realign); end
            end
        end
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL b2b_end_vld got %b want 0", vld); end
    endtask

    task automatic test_realign();
        logic [39:0] a_lo, b_lo;
        a_lo  = 40'h12_3456_789A;
        b_lo  = 40'hA_BCDE_F012;
        ready = 1'b1;
        beat(2'd1, 80'hFFFF_FFFF_FFFF_FFFF_FFFF);
        beat(2'd1, 80'hEEEE_EEEE_EEEE_EEEE_EEEE);
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL realign_pre_vld got %b want 0", vld); end
        beat(2'd2, {40'hDE_ADBE_EF00, a_lo});
        n_cmp++; if (realign !== 1'b1) begin n_err++; $display("FAIL realign_pulse got %b want 1", realign); end
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL realign_mid_vld got %b want 0", vld); end
        beat(2'd2, {40'hC0_FFEE_C0FF, b_lo});
        n_cmp++; if (realign !== 1'b0) begin n_err++; $display("FAIL realign_single got %b want 0", realign); end
        n_cmp++; if (vld !== 1'b1) begin n_err++; $display("FAIL realign_vld got %b want 1", vld); end
        n_cmp++; if (dout !== {b_lo, a_lo}) begin n_err++; $display("FAIL realign_word got %h want %h", dout, {b_lo, a_lo}); end
        tick();
    endtask

    task automatic test_overflow();
        logic [79:0] p, q, r;
        p     = 80'h1111_2222_3333_4444_5555;
        q     = 80'hAAAA_AAAA_AAAA_AAAA_AAAA;
        r     = 80'h5A5A_5A5A_5A5A_5A5A_5A5A;
        ready = 1'b0;
        beat(2'd3, p);
        n_cmp++; if (vld !== 1'b1 || dout !== p) begin n_err++; $display("FAIL ovf_first got vld=%b %h want vld=1 %h", vld, dout, p); end
        n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_none got %b want 0", ovf); end
        beat(2'd3, q);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse1 got %b want 1", ovf); end
        n_cmp++; if (dout !== p) begin n_err++; $display("FAIL ovf_hold1 got %h want %h", dout, p); end
        beat(2'd3, r);
        n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_pulse2 got %b want 1", ovf); end
        n_cmp++; if (dout !== p || vld !== 1'b1) begin n_err++; $display("FAIL ovf_hold2 got vld=%b %h want vld=1 %h", vld, dout, p); end
        tick();
        n_cmp++; if (ovf !== 1'b0 || vld !== 1'b1) begin n_err++; $display("FAIL ovf_idle got ovf=%b vld=%b want ovf=0 vld=1", ovf, vld); end
        ready = 1'b1;
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL ovf_xfer_vld got %b want 0", vld); end
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL ovf_single_xfer got %b want 0", vld); end
    endtask

    task automatic test_width_err();
        r4 = 1'b1;
        w4 = 2'd3;
        v4 = 1'b0;
        tick();
        n_cmp++; if (werr4 !== 1'b0) begin n_err++; $display("FAIL werr_novalid got %b want 0", werr4); end
        beat4(2'd0, 40'h11);
        beat4(2'd3, 40'hFF_FFFF_FFFF);
        n_cmp++; if (werr4 !== 1'b1) begin n_err++; $display("FAIL werr_pulse got %b want 1", werr4); end
        beat4(2'd0, 40'h12);
        n_cmp++; if (werr4 !== 1'b0) begin n_err++; $display("FAIL werr_once got %b want 0", werr4); end
        beat4(2'd0, 40'h13);
        n_cmp++; if (vld4 !== 1'b0) begin n_err++; $display("FAIL werr_fill_vld got %b want 0", vld4); end
        beat4(2'd0, 40'h14);
        n_cmp++; if (vld4 !== 1'b1) begin n_err++; $display("FAIL werr_vld got %b want 1", vld4); end
        n_cmp++; if (dout4 !== 40'h05_0130_4811) begin n_err++; $display("FAIL werr_word got %h want 0501304811", dout4); end
        n_cmp++; if (realign4 !== 1'b0) begin n_err++; $display("FAIL werr_realign got %b want 0", realign4); end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [79:0] exp;
        ready = 1'b1;
        for (int i = 0; i < 5; i++)
            beat(2'd0, 80'(10'h0A0 + i));
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL rstmid_pre_vld got %b want 0", vld); end
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp[i*10 +: 10] = 10'(10'h101 + i);
            beat(2'd0, 80'(10'h101 + i));
            if (i == 6) begin
                n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL rstmid_early_vld got %b want 0", vld); end
            end
        end
        n_cmp++; if (vld !== 1'b1 || dout !== exp) begin n_err++; $display("FAIL rstmid_word got vld=%b %h want vld=1 %h", vld, dout, exp); end
        tick();
    endtask

    task automatic test_flush();
        logic [79:0] p2, exp;
        p2    = 80'h0F0F_1E1E_2D2D_3C3C_4B4B;
        ready = 1'b0;
        beat(2'd3, p2);
        for (int i = 0; i < 5; i++)
            beat(2'd0, 80'(10'h0B0 + i));
        flush   = 1'b1;
        rxvalid = 1'b1;
        rxwidth = 2'd0;
        rxdata  = 80'h3FF;
        tick();
        flush   = 1'b0;
        rxvalid = 1'b0;
        n_cmp++; if (vld !== 1'b1 || dout !== p2) begin n_err++; $display("FAIL flush_hold got vld=%b %h want vld=1 %h", vld, dout, p2); end
        n_cmp++; if (realign !== 1'b0) begin n_err++; $display("FAIL flush_realign got %b want 0", realign); end
        ready = 1'b1;
        tick();
        n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL flush_xfer got %b want 0", vld); end
        for (int i = 0; i < 8; i++) begin
            exp[i*10 +: 10] = 10'(10'h201 + i);
            beat(2'd0, 80'(10'h201 + i));
            if (i == 6) begin
                n_cmp++; if (vld !== 1'b0) begin n_err++; $display("FAIL flush_early_vld got %b want 0", vld); end
            end
        end
        n_cmp++; if (vld !== 1'b1 || dout !== exp) begin n_err++; $display("FAIL flush_word got vld=%b %h want vld=1 %h", vld, dout, exp); end
        tick();
    endtask

    initial begin
        reset_i = 1'b1;
        rxwidth = '0;
        rxvalid = 1'b0;
        rxdata  = '0;
        flush   = 1'b0;
        ready   = 1'b0;
        w4      = '0;
        v4      = 1'b0;
        d4      = '0;
        f4      = 1'b0;
        r4      = 1'b0;
        test_reset();
        test_narrow();
        test_back_to_back();
        test_realign();
        test_overflow();
        test_width_err();
        test_reset_mid();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tc_pcie_rx_gearbox.md
Name: tc_pcie_rx_gearbox

Overview:
- Parametrised successor to the fixed 10/20/40/80-to-80-bit rx converter.
- Packs PHY rx beats of 1, 2, 4 … MAX_SYMS symbols into full OUT_W-bit words, all in a single clock domain.
- Uses a valid/ready output handshake instead of a derived divided clock.
- Adds dynamic width-change realignment, flush, illegal-width detection and overflow detection; sits between PHY rx datapath and the PCS block aligner.

Parameters:
- SYM_W, 10, bits per symbol.
- MAX_SYMS, 8, symbols per output word; power of two, ≥2.
- OUT_W, SYM_W*MAX_SYMS, output word width (derived, not overridden).
- WSEL_W, $clog2($clog2(MAX_SYMS)+1), width-select field width (derived).

Ports:
- rxclk_i  in  1  single block clock.
- reset_i  in  1  synchronous, active-high reset.
- rxwidth_i  in  WSEL_W  log2(symbols per beat): 0=1 sym … log2(MAX_SYMS)=full word; larger codes illegal.
- rxvalid_i  in  1  beat qualifier.
- rxdata_i  in  OUT_W  beat data; low (2^rxwidth_i)*SYM_W bits meaningful, rest ignored.
- flush_i  in  1  discard partial accumulation.
- rxdata_o  out  OUT_W  packed word; first-received symbol at [SYM_W-1:0].
- rxvalid_o  out  1  word available.
- rxready_i  in  1  downstream accept.
- realign_o  out  1  one-cycle pulse: partial word discarded on width change.
- overflow_o  out  1  one-cycle pulse: completed word dropped.
- width_err_o  out  1  one-cycle pulse: beat with illegal rxwidth_i ignored.

Behaviour:
- Reset is synchronous, active-high, sampled on rising rxclk_i. It clears accumulator, fill count, locked width (0), rxdata_o=0, rxvalid_o=0 and all pulses. Reset mid-word drops the partial and any pending output.
- State: fill_r symbol count (0..MAX_SYMS-1), width_r locked width, acc_r accumulator, out_r/rxvalid_o output holding register.
- Accepted beat (rxvalid_i=1, legal width, no flush):
  - If rxwidth_i != width_r and fill_r != 0: discard the partial, pulse realign_o, start fresh with this beat at fill 0, load width_r.
  - If fill_r == 0: load width_r silently.
  - Beat symbols are written to acc at symbol positions fill_r .. fill_r+2^w-1; fill_r advances by 2^w.
  - Word completes when fill_r+2^w == MAX_SYMS. fill_r wraps to 0 and the completed word (including this beat) goes to out_r.
- Latency: rxvalid_o asserts the cycle after the completing beat. In full-width mode every valid beat yields a word one cycle later (back-to-back at full rate).
- Handshake: rxdata_o is stable while rxvalid_o=1 and rxready_i=0. The word is transferred when rxvalid_o && rxready_i; rxvalid_o deasserts the next cycle unless a new word loads.
- Word completes while rxvalid_o=1 and rxready_i=0: the new word is dropped, the old one is retained, overflow_o pulses.
- Word completes in the same cycle as a transfer: the new word is loaded, rxvalid_o stays 1, no overflow.
- Illegal rxwidth_i with rxvalid_i=1: beat ignored, acc/fill/width_r unchanged, width_err_o pulses. Illegal code with rxvalid_i=0 has no effect.
- flush_i=1: fill_r is set to 0 and the partial is discarded; any concurrent beat is ignored. The output register and handshake are unaffected; no realign_o.
- rxvalid_i=0: no state change in accumulator.
- Pulses are registered, asserted the cycle after the causing beat, for exactly one cycle.
- Unused acc positions never leak: a completed word contains only symbols from the current alignment.

Test Plan:
- MAX_SYMS=8, rxwidth_i=0, 8 beats symbols 0x001..0x008 -> rxvalid_o=1 one cycle after 8th beat, rxdata_o[9:0]=0x001, rxdata_o[79:70]=0x008.
- rxwidth_i=3, 4 back-to-back beats, rxready_i=1 -> 4 consecutive words, each equal to its input, rxvalid_o high 4 cycles, 1-cycle latency.
- rxwidth_i=1, 2 beats, then rxwidth_i=2 beat A, beat B -> realign_o pulses once, first 40 bits dropped, word = {B[39:0],A[39:0]}.
- rxready_i=0 with word pending, 2 further full-width beats -> overflow_o pulses twice, rxdata_o holds first word; raise rxready_i -> single transfer, rxvalid_o drops.
- MAX_SYMS=4 (WSEL_W=2), rxvalid_i=1 with rxwidth_i=3 -> width_err_o pulse, fill unchanged; subsequent legal beats pack normally.
- 10-bit mode, 5 beats, then reset_i=1 one cycle, then 8 beats -> no word from the first 5; one correct word from the next 8. Same sequence with flush_i instead of reset -> same result, any pending output preserved.
